// File: rtl/mult_seq.sv
// Radix-2 shift-add 32x32 multiplier for MULT/MULTU; MULT_SIGNED_EN adds signed (magnitude/negate) support.
// Latency: 33 falling edges from start acceptance to hi/lo + done; back-to-back issue every 34 edges.
// Backpressure: busy high while an operation is in flight; start is ignored outside IDLE.
module mult_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state, state_nxt;
   logic [32:0] acc, acc_nxt, sum;
   logic [31:0] mc, mc_nxt, mp, mp_nxt;
   logic [31:0] hi_nxt, lo_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic        busy_nxt, done_nxt;
   logic [31:0] a_mag, b_mag;
   logic [63:0] p, p_out;

   assign p   = {acc[31:0], mp};
   assign sum = acc + {1'b0, (mp[0] ? mc : 32'd0)};

`ifdef MULT_SIGNED_EN
   logic neg, op_neg;

   assign a_mag  = (is_signed && multiplicand[31]) ? (~multiplicand + 32'd1) : multiplicand;
   assign b_mag  = (is_signed && multiplier[31])   ? (~multiplier + 32'd1)   : multiplier;
   assign op_neg = is_signed & (multiplicand[31] ^ multiplier[31]);
   assign p_out  = neg ? (~p + 64'd1) : p;

   always_ff @(negedge clock) begin
      if (reset)
         neg <= 1'b0;
      else if (state == IDLE && start)
         neg <= op_neg;
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign a_mag = multiplicand;
   assign b_mag = multiplier;
   assign p_out = p;
`endif

   always_ff @(negedge clock) begin
      if (reset) begin
         state <= IDLE;
         acc   <= '0;
         mc    <= '0;
         mp    <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         mc    <= mc_nxt;
         mp    <= mp_nxt;
         cnt   <= cnt_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      mc_nxt    = mc;
      mp_nxt    = mp;
      cnt_nxt   = cnt;
      hi_nxt    = hi;
      lo_nxt    = lo;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mc_nxt    = a_mag;
               mp_nxt    = b_mag;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // Product low bits shift into mp as the multiplier bits are consumed.
            acc_nxt = {1'b0, sum[32:1]};
            mp_nxt  = {sum[0], mp[31:1]};
            cnt_nxt = cnt + 5'd1;
            if (cnt == 5'd31)
               state_nxt = FIX;
         end
         FIX: begin
            {hi_nxt, lo_nxt} = p_out;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases plus randomized operands against a plain-arithmetic model.
module tb_mult_seq;
`ifdef MULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset, start, is_signed;
   logic [31:0] multiplicand, multiplier, hi, lo;
   logic        busy, done;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clock = ~clock;

   mult_seq dut (
      .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   // Advance past one falling (active) edge and settle before sampling/driving.
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s && SIGNED_EN)
         return 64'(sa * sb);
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one operation (start sampled at E0) and check busy/done/hi/lo on every edge through E33.
   // glitch: edge index at which a competing 9x9 start is pulsed (0 = none).
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int glitch, input logic [63:0] exp, input string tag);
      logic [63:0] prev;
      prev         = {hi, lo};
      start        = 1'b1;
      is_signed    = s;
      multiplicand = a;
      multiplier   = b;
      tick();
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      is_signed    = 1'($urandom_range(0, 1));
      check({tag, " E0"}, {busy, done, hi, lo}, {2'b10, prev});
      for (int e = 1; e <= 32; e++) begin
         if (e == glitch) begin
            start        = 1'b1;
            multiplicand = 32'd9;
            multiplier   = 32'd9;
         end
         tick();
         start = 1'b0;
         check({tag, " run"}, {busy, done, hi, lo}, {2'b10, prev});
      end
      tick();
      check({tag, " E33"}, {busy, done, hi, lo}, {2'b01, exp});
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      logic [63:0] exp;

      reset = 1'b1; start = 1'b0; is_signed = 1'b0;
      multiplicand = '0; multiplier = '0;
      tick();
      tick();
      check("reset state", {busy, done, hi, lo}, 66'd0);
      reset = 1'b0;

      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001, "u_max");
      tick();
      check("u_max E34", {busy, done, hi, lo}, {2'b00, 64'hFFFF_FFFE_0000_0001});

      exp = SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0006_FFFF_FFEB;
      do_mult(32'hFFFF_FFFD, 32'd7, 1'b1, 0, exp, "s_m3x7");
      do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 64'h4000_0000_0000_0000, "s_min");
      exp = SIGNED_EN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001;
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, exp, "s_m1");
      do_mult(32'd5, 32'd6, 1'b0, 10, 64'd30, "ign_start");
      tick();
      check("ign_start idle", {busy, done, hi, lo}, {2'b00, 64'd30});

      // Abort a run with reset at E10; no done may follow.
      start = 1'b1; is_signed = 1'b0; multiplicand = 32'd5; multiplier = 32'd6;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 9; e++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort", {busy, done, hi, lo}, 66'd0);
      for (int e = 0; e < 40; e++) begin
         tick();
         check("abort quiet", {busy, done, hi, lo}, 66'd0);
      end

      do_mult(32'd0, 32'h1234_5678, 1'b0, 0, 64'd0, "zero");
      do_mult(32'd3, 32'd5, 1'b0, 0, 64'd15, "b2b");

      for (int i = 0; i < 16; i++) begin
         a = pick_operand();
         b = pick_operand();
         s = 1'($urandom_range(0, 1));
         do_mult(a, b, s, (i % 3 == 0) ? int'($urandom_range(1, 32)) : 0, ref_mul(a, b, s), "rand");
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            tick();
            check("rand idle", {busy, done, hi, lo}, {2'b00, ref_mul(a, b, s)});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
